// File: rtl/instruction_decoder_pkg.sv
// rtl/instruction_decoder_pkg.sv - bit positions, widths and types for the Hack-style instruction decoder
package instruction_decoder_pkg;

  localparam int INSTR_W  = 16;
  localparam int CNT_W    = 16;

  localparam int TYPE_BIT = 15;
  localparam int A_BIT    = 12;
  localparam int DEST_A   = 5;
  localparam int DEST_D   = 4;
  localparam int DEST_M   = 3;
  localparam int J1       = 2;
  localparam int J2       = 1;
  localparam int J3       = 0;

  typedef enum logic {
    INSTR_A = 1'b0,
    INSTR_C = 1'b1
  } instr_type_e;

  typedef struct packed {
    logic we_a;
    logic we_d;
    logic we_m;
    logic pc_e;
    logic a;
  } ctrl_t;

  // Only the top bit distinguishes the two instruction classes; bits 14:13 are don't-care.
  function automatic instr_type_e instr_type(input logic [INSTR_W-1:0] instr);
    return instr_type_e'(instr[TYPE_BIT]);
  endfunction

endpackage

// File: rtl/instruction_decoder_jump_eval.sv
// rtl/instruction_decoder_jump_eval.sv - combinational jump condition from the jump field and ALU flags
module jump_eval
  import instruction_decoder_pkg::*;
(
  input  logic [2:0] jmp,
  input  logic       Zy,
  input  logic       Cy,
  output logic       pc_e
);

  logic neg;
  logic pos;

  // Zy wins over Cy: a zero result with the sign flag set still counts as zero.
  always_comb begin
    neg  = Cy & ~Zy;
    pos  = ~Cy & ~Zy;
    pc_e = (jmp[J1] & neg) | (jmp[J2] & Zy) | (jmp[J3] & pos);
  end

endmodule

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - registered Hack instruction decoder; DECODER_STATS_EN adds instruction/jump counters
module instruction_decoder
  import instruction_decoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               Zy,
  input  logic               Cy,
  output logic               we_a,
  output logic               we_d,
  output logic               we_m,
  output logic               PC_e,
  output logic               a
`ifdef DECODER_STATS_EN
  ,
  output logic [CNT_W-1:0]   cnt_a,
  output logic [CNT_W-1:0]   cnt_c,
  output logic [CNT_W-1:0]   cnt_jmp
`endif
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  jump_pc_e;
  logic  unused_comp;

  // The comp field and the don't-care type bits never affect this block.
  assign unused_comp = ^instr[14:6];

  jump_eval u_jump_eval (
    .jmp  (instr[J1:J3]),
    .Zy   (Zy),
    .Cy   (Cy),
    .pc_e (jump_pc_e)
  );

  always_comb begin
    ctrl_d = '0;
    if (instr_type(instr) == INSTR_A) begin
      ctrl_d.we_a = 1'b1;
    end else begin
      ctrl_d.a    = instr[A_BIT];
      ctrl_d.we_a = instr[DEST_A];
      ctrl_d.we_d = instr[DEST_D];
      ctrl_d.we_m = instr[DEST_M];
      ctrl_d.pc_e = jump_pc_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign we_a = ctrl_q.we_a;
  assign we_d = ctrl_q.we_d;
  assign we_m = ctrl_q.we_m;
  assign PC_e = ctrl_q.pc_e;
  assign a    = ctrl_q.a;

`ifdef DECODER_STATS_EN
  logic [CNT_W-1:0] cnt_a_d;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_c_d;
  logic [CNT_W-1:0] cnt_c_q;
  logic [CNT_W-1:0] cnt_jmp_d;
  logic [CNT_W-1:0] cnt_jmp_q;

  // Counters wrap naturally at the counter width.
  always_comb begin
    cnt_a_d   = cnt_a_q;
    cnt_c_d   = cnt_c_q;
    cnt_jmp_d = cnt_jmp_q;
    if (instr_type(instr) == INSTR_A) begin
      cnt_a_d = cnt_a_q + CNT_W'(1);
    end else begin
      cnt_c_d = cnt_c_q + CNT_W'(1);
    end
    if (ctrl_d.pc_e) begin
      cnt_jmp_d = cnt_jmp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q   <= '0;
      cnt_c_q   <= '0;
      cnt_jmp_q <= '0;
    end else begin
      cnt_a_q   <= cnt_a_d;
      cnt_c_q   <= cnt_c_d;
      cnt_jmp_q <= cnt_jmp_d;
    end
  end

  assign cnt_a   = cnt_a_q;
  assign cnt_c   = cnt_c_q;
  assign cnt_jmp = cnt_jmp_q;
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// tb/tb_instruction_decoder.sv - scoreboard bench for instruction_decoder (counter checks with DECODER_STATS_EN)
module tb_instruction_decoder;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        Zy;
  logic        Cy;
  logic        we_a;
  logic        we_d;
  logic        we_m;
  logic        PC_e;
  logic        a;
`ifdef DECODER_STATS_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_c;
  logic [15:0] cnt_jmp;
`endif

  instruction_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .Zy      (Zy),
    .Cy      (Cy),
    .we_a    (we_a),
    .we_d    (we_d),
    .we_m    (we_m),
    .PC_e    (PC_e),
    .a       (a)
`ifdef DECODER_STATS_EN
    ,
    .cnt_a   (cnt_a),
    .cnt_c   (cnt_c),
    .cnt_jmp (cnt_jmp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  outs;
    logic [15:0] ca;
    logic [15:0] cc;
    logic [15:0] cj;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_ca = 0;
  logic [15:0] m_cc = 0;
  logic [15:0] m_cj = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hack jump mnemonics, written as a table rather than as the sum-of-products form.
  function automatic logic model_jump(input logic [2:0] j, input logic z, input logic c);
    logic is_zero, is_neg, is_pos;
    is_zero = z;
    is_neg  = c && !z;
    is_pos  = !c && !z;
    case (j)
      3'b000:  return 1'b0;
      3'b001:  return is_pos;
      3'b010:  return is_zero;
      3'b011:  return is_zero || is_pos;
      3'b100:  return is_neg;
      3'b101:  return !is_zero;
      3'b110:  return is_neg || is_zero;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [4:0] model_outs(input logic [15:0] w, input logic z, input logic c);
    logic [4:0] o;
    if (!w[15]) o = 5'b10000;
    else        o = {w[5], w[4], w[3], model_jump(w[2:0], z, c), w[12]};
    return o;
  endfunction

  task automatic do_cycle(input string tag, input logic [15:0] w, input logic z, input logic c);
    exp_t e;
    exp_t got_e;
    @(negedge clk);
    instr = w;
    Zy    = z;
    Cy    = c;
    e.outs = model_outs(w, z, c);
    if (w[15]) m_cc = m_cc + 16'd1;
    else       m_ca = m_ca + 16'd1;
    if (e.outs[1]) m_cj = m_cj + 16'd1;
    e.ca = m_ca;
    e.cc = m_cc;
    e.cj = m_cj;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got_e = sb.pop_front();
      check({tag, "_outs"}, {27'd0, we_a, we_d, we_m, PC_e, a}, {27'd0, got_e.outs});
`ifdef DECODER_STATS_EN
      check({tag, "_cnt_a"}, {16'd0, cnt_a}, {16'd0, got_e.ca});
      check({tag, "_cnt_c"}, {16'd0, cnt_c}, {16'd0, got_e.cc});
      check({tag, "_cnt_jmp"}, {16'd0, cnt_jmp}, {16'd0, got_e.cj});
`endif
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {27'd0, we_a, we_d, we_m, PC_e, a}, 32'd0);
`ifdef DECODER_STATS_EN
    check({tag, "_cnts"}, {cnt_a, cnt_c ^ cnt_jmp}, 32'd0);
    check({tag, "_cnt_jmp"}, {16'd0, cnt_jmp}, 32'd0);
`endif
  endtask

  initial begin
    rst   = 1'b1;
    instr = 16'h813B;
    Zy    = 1'b1;
    Cy    = 1'b0;
    #1;
    check_all_zero("reset_async");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    #2;
    rst = 1'b0;

    do_cycle("a_instr_0056", 16'h0056, 1'b0, 1'b0);
    check("exact_0056", {27'd0, we_a, we_d, we_m, PC_e, a}, 32'h10);
    do_cycle("jne_not_taken", 16'h8045, 1'b1, 1'b0);
    check("exact_8045", {27'd0, we_a, we_d, we_m, PC_e, a}, 32'h00);
    do_cycle("jge_taken", 16'h813B, 1'b1, 1'b0);
    check("exact_813b", {27'd0, we_a, we_d, we_m, PC_e, a}, 32'h1E);
`ifdef DECODER_STATS_EN
    check("stats_cnt_a", {16'd0, cnt_a}, 32'd1);
    check("stats_cnt_c", {16'd0, cnt_c}, 32'd2);
    check("stats_cnt_jmp", {16'd0, cnt_jmp}, 32'd1);
`endif
    do_cycle("jlt_taken", 16'h9004, 1'b0, 1'b1);
    check("exact_9004_neg", {30'd0, PC_e, a}, 32'h3);
    do_cycle("jlt_not_taken", 16'h9004, 1'b0, 1'b0);
    check("exact_9004_pos", {30'd0, PC_e, a}, 32'h1);

    // Every jump field against every flag pair, including Zy=Cy=1; type bits 14:13 vary.
    for (int j = 0; j < 8; j++) begin
      for (int f = 0; f < 4; f++) begin
        logic [15:0] w;
        w = 16'($urandom);
        w[15]  = 1'b1;
        w[2:0] = 3'(j);
        do_cycle("jump_sweep", w, f[1], f[0]);
      end
    end

    for (int i = 0; i < 150; i++) begin
      do_cycle("random", 16'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset between edges must clear outputs immediately and drop the pending decode.
    do_cycle("pre_reset", 16'h813B, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_cycle");
    m_ca = 0;
    m_cc = 0;
    m_cj = 0;
    @(negedge clk);
    instr = 16'h9007;
    Zy    = 1'b0;
    Cy    = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("reset_edge_ignored");
    #2;
    rst = 1'b0;
    do_cycle("post_reset_0056", 16'h0056, 1'b0, 1'b0);
    check("post_reset_we_a", {31'd0, we_a}, 32'd1);
    do_cycle("post_reset_jmp", 16'hE007, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
